// File: rtl/score_display_scheduler_pkg.sv
// Shared encodings for the score display scan: slot order, FSM states, score limit.
// No logic of its own beyond the score clamp helper.
// No flow control; constants and a pure function only.
package score_display_scheduler_pkg;

  // Scan slot order, left to right on the display
  localparam logic [1:0] SLOT_A_TENS = 2'd0;
  localparam logic [1:0] SLOT_A_ONES = 2'd1;
  localparam logic [1:0] SLOT_B_TENS = 2'd2;
  localparam logic [1:0] SLOT_B_ONES = 2'd3;

  localparam logic [6:0] SCORE_MAX = 7'd99;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_SHOW = 2'd2
  } state_e;

  // Two decimal digits cannot show more than 99
  function automatic logic [6:0] clamp_score(input logic [6:0] s);
    return (s > SCORE_MAX) ? SCORE_MAX : s;
  endfunction

endpackage

// File: rtl/score_display_scheduler_bin2dec.sv
// Shared binary-to-decimal converter: splits a 0..99 score into tens and ones.
// Latency: purely combinational, result valid in the same cycle as bin_i.
// No backpressure; the scheduler holds bin_i stable for the whole capture cycle.
module score_display_scheduler_bin2dec (
  input  logic [6:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  // Divide by a constant; only 0..99 is meaningful to the scheduler
  always_comb begin
    tens_o = 4'(bin_i / 7'd10);
    ones_o = 4'(bin_i % 7'd10);
  end

endmodule

// File: rtl/score_display_scheduler.sv
// Scans two clamped scores over a 4-digit display through one external converter.
// Latency: 1-cycle dark convert gap then REFRESH_DIV cycles lit per slot; ack 1 cycle after apply.
// No backpressure: updates are absorbed in pending regs and applied only at a frame boundary.
module score_display_scheduler
  import score_display_scheduler_pkg::*;
#(
  parameter int unsigned REFRESH_DIV        = 1000,
  parameter bit          BLANK_LEADING_ZERO = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic [6:0] score_a_i,
  input  logic [6:0] score_b_i,
  input  logic       update_i,
  output logic       update_ack_o,
  output logic [6:0] bin_o,
  input  logic [3:0] tens_i,
  input  logic [3:0] ones_i,
  output logic [3:0] digit_o,
  output logic [3:0] digit_sel_o,
  output logic       blank_o
);

  localparam int unsigned CW = $clog2(REFRESH_DIV + 1);

  state_e          state_q, state_d;
  logic [1:0]      slot_q, slot_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [6:0]      live_a_q, live_a_d, live_b_q, live_b_d;
  logic [6:0]      pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic            pend_q, pend_d;
  logic [6:0]      bin_q, bin_d;
  logic [3:0]      digit_q, digit_d;
  logic [3:0]      sel_q, sel_d;
  logic            blank_q, blank_d;
  logic            ack_q, ack_d;
  logic            boundary;
  logic            apply;
  logic            tens_slot;

  // Next-state: score latching (tear-free) and the scan sequence
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    cnt_d    = cnt_q;
    live_a_d = live_a_q;
    live_b_d = live_b_q;
    pend_a_d = pend_a_q;
    pend_b_d = pend_b_q;
    pend_d   = pend_q;
    bin_d    = bin_q;
    digit_d  = digit_q;
    sel_d    = sel_q;
    blank_d  = blank_q;
    ack_d    = 1'b0;

    tens_slot = (slot_q == SLOT_A_TENS) || (slot_q == SLOT_B_TENS);
    boundary  = (state_q == ST_SHOW) && (slot_q == SLOT_B_ONES) && (cnt_q == '0);
    // Live scores may only change where no frame is half drawn
    apply     = (state_q == ST_IDLE) || !enable_i || boundary;

    if (apply) begin
      pend_d = 1'b0;
      if (update_i) begin
        live_a_d = clamp_score(score_a_i);
        live_b_d = clamp_score(score_b_i);
        ack_d    = 1'b1;
      end else if (pend_q) begin
        live_a_d = pend_a_q;
        live_b_d = pend_b_q;
        ack_d    = 1'b1;
      end
    end else if (update_i) begin
      pend_a_d = clamp_score(score_a_i);
      pend_b_d = clamp_score(score_b_i);
      pend_d   = 1'b1;
    end

    if (!enable_i) begin
      state_d = ST_IDLE;
      slot_d  = SLOT_A_TENS;
      cnt_d   = '0;
      bin_d   = 7'd0;
      sel_d   = 4'b0000;
      blank_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_CONV;
          slot_d  = SLOT_A_TENS;
          bin_d   = live_a_d;
          sel_d   = 4'b0000;
          blank_d = 1'b1;
        end
        ST_CONV: begin
          digit_d = tens_slot ? tens_i : ones_i;
          state_d = ST_SHOW;
          cnt_d   = CW'(REFRESH_DIV - 1);
          if (BLANK_LEADING_ZERO && tens_slot && (digit_d == 4'd0)) begin
            sel_d   = 4'b0000;
            blank_d = 1'b1;
          end else begin
            sel_d   = 4'b0001 << slot_q;
            blank_d = 1'b0;
          end
        end
        ST_SHOW: begin
          if (cnt_q == '0) begin
            slot_d  = slot_q + 2'd1;
            state_d = ST_CONV;
            sel_d   = 4'b0000;
            blank_d = 1'b1;
            bin_d   = ((slot_d == SLOT_A_TENS) || (slot_d == SLOT_A_ONES)) ? live_a_d : live_b_d;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          slot_d  = SLOT_A_TENS;
          cnt_d   = '0;
          bin_d   = 7'd0;
          sel_d   = 4'b0000;
          blank_d = 1'b1;
        end
      endcase
    end
  end

  // State and registered outputs, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      slot_q   <= SLOT_A_TENS;
      cnt_q    <= '0;
      live_a_q <= 7'd0;
      live_b_q <= 7'd0;
      pend_a_q <= 7'd0;
      pend_b_q <= 7'd0;
      pend_q   <= 1'b0;
      bin_q    <= 7'd0;
      digit_q  <= 4'd0;
      sel_q    <= 4'b0000;
      blank_q  <= 1'b1;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      cnt_q    <= cnt_d;
      live_a_q <= live_a_d;
      live_b_q <= live_b_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      pend_q   <= pend_d;
      bin_q    <= bin_d;
      digit_q  <= digit_d;
      sel_q    <= sel_d;
      blank_q  <= blank_d;
      ack_q    <= ack_d;
    end
  end

  assign update_ack_o = ack_q;
  assign bin_o        = bin_q;
  assign digit_o      = digit_q;
  assign digit_sel_o  = sel_q;
  assign blank_o      = blank_q;

endmodule

// File: tb/tb_score_display_scheduler.sv
// Bench for the score display scheduler: two instances (leading-zero blanking on/off).
// Expected outputs come from a frame-position model of the display.
// Inputs are driven 1 ns after each rising edge; outputs sampled there too.
module tb_score_display_scheduler;

  localparam int R = 4;
  localparam int F = 4 * (R + 1);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, upd;
  logic [6:0] sa, sb;

  logic       ack0, ack1, blank0, blank1;
  logic [6:0] bin0, bin1;
  logic [3:0] tens0, ones0, tens1, ones1, digit0, digit1, sel0, sel1;

  int checks = 0;
  int failures = 0;

  // Model state
  bit         m_run;
  int         m_pos, m_la, m_lb, m_pa, m_pb;
  bit         m_pend;
  bit         e_ack, e_blank, e_blank_nb, chk_digit, chk_bin;
  logic [3:0] e_sel, e_sel_nb, e_digit;
  logic [6:0] e_bin;

  score_display_scheduler #(.REFRESH_DIV(R), .BLANK_LEADING_ZERO(1'b1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .score_a_i(sa), .score_b_i(sb),
    .update_i(upd), .update_ack_o(ack0), .bin_o(bin0), .tens_i(tens0), .ones_i(ones0),
    .digit_o(digit0), .digit_sel_o(sel0), .blank_o(blank0));
  score_display_scheduler_bin2dec conv0 (.bin_i(bin0), .tens_o(tens0), .ones_o(ones0));

  score_display_scheduler #(.REFRESH_DIV(R), .BLANK_LEADING_ZERO(1'b0)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .score_a_i(sa), .score_b_i(sb),
    .update_i(upd), .update_ack_o(ack1), .bin_o(bin1), .tens_i(tens1), .ones_i(ones1),
    .digit_o(digit1), .digit_sel_o(sel1), .blank_o(blank1));
  score_display_scheduler_bin2dec conv1 (.bin_i(bin1), .tens_o(tens1), .ones_o(ones1));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_la = 0; m_lb = 0; m_pa = 0; m_pb = 0; m_pend = 0;
    e_ack = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_edge();
    int ca, cb, slot, ph, val, dig;
    bit apply;
    ca = (sa > 99) ? 99 : int'(sa);
    cb = (sb > 99) ? 99 : int'(sb);
    apply = !m_run || !en || (m_pos == F - 1);
    e_ack = apply && (upd || m_pend);
    if (apply) begin
      if (upd) begin m_la = ca; m_lb = cb; end
      else if (m_pend) begin m_la = m_pa; m_lb = m_pb; end
      m_pend = 0;
    end else if (upd) begin
      m_pa = ca; m_pb = cb; m_pend = 1;
    end
    if (!en) m_run = 0;
    else if (!m_run) begin m_run = 1; m_pos = 0; end
    else m_pos = (m_pos + 1) % F;

    e_sel = 4'h0; e_blank = 1; e_sel_nb = 4'h0; e_blank_nb = 1;
    chk_digit = 0; chk_bin = 0; e_digit = 4'h0; e_bin = 7'h0;
    if (m_run) begin
      slot = m_pos / (R + 1);
      ph   = m_pos % (R + 1);
      val  = (slot < 2) ? m_la : m_lb;
      dig  = (slot % 2 == 0) ? val / 10 : val % 10;
      if (ph == 0) begin
        chk_bin = 1; e_bin = 7'(val);
      end else begin
        chk_digit = 1; e_digit = 4'(dig);
        e_sel_nb = 4'b0001 << slot; e_blank_nb = 0;
        if (!((slot % 2 == 0) && (dig == 0))) begin
          e_sel = e_sel_nb; e_blank = 0;
        end
      end
    end else begin
      chk_bin = 1; e_bin = 7'h0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [21:0] obs_vec();
    return {sel0, blank0, ack0, sel1, blank1, chk_digit ? digit0 : 4'h0, chk_bin ? bin0 : 7'h0};
  endfunction

  function automatic logic [21:0] exp_vec();
    return {e_sel, e_blank, e_ack, e_sel_nb, e_blank_nb, e_digit, e_bin};
  endfunction

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 4; i++) begin
      en = 1'($urandom); upd = 1'($urandom); sa = 7'($urandom); sb = 7'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({sel0, blank0, ack0, digit0, bin0, sel1, blank1} !== {4'h0, 1'b1, 1'b0, 4'h0, 7'h0, 4'h0, 1'b1}) begin
        failures++;
        $display("FAIL reset_hold: sel=%b blank=%b ack=%b digit=%0d bin=%0d, need 0000/1/0/0/0", sel0, blank0, ack0, digit0, bin0);
      end
    end
    en = 0; upd = 0; sa = 0; sb = 0;
    model_reset();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL reset_release_dark: got %h need %h", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_basic_scan();
    sa = 42; sb = 7; upd = 1;
    tick(); upd = 0;
    checks++;
    if (ack0 !== 1'b1) begin
      failures++; $display("FAIL idle_update_ack: ack=%b need 1", ack0);
    end
    en = 1;
    for (int i = 0; i < 2 * F; i++) begin
      tick(); checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL basic_scan cyc %0d: got %h need %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_clamp_zero();
    en = 0; sa = 120; sb = 0; upd = 1;
    tick(); upd = 0; en = 1;
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL clamp_idle: got %h need %h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < F + 2; i++) begin
      tick(); checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL clamp_zero cyc %0d: got %h need %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_tear_free();
    int acks = 0;
    int guard = 0;
    while (!(m_run && m_pos == R + 3) && guard < 3 * F) begin
      tick(); guard++; checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL tear_wait: got %h need %h", obs_vec(), exp_vec());
      end
    end
    sa = 55; sb = 7; upd = 1;
    for (int i = 0; i < 2 * F; i++) begin
      tick();
      if (i == 0) upd = 0;
      if (i == 2) begin sa = 63; upd = 1; end
      if (i == 3) upd = 0;
      if (ack0 === 1'b1) acks++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL tear_free cyc %0d: got %h need %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (acks != 1) begin
      failures++; $display("FAIL tear_ack_count: got %0d need 1", acks);
    end
  endtask

  task automatic test_coincident_disable();
    int guard = 0;
    while (!(m_run && m_pos == F - 1) && guard < 2 * F) begin
      tick(); guard++;
    end
    sa = 18; sb = 7; upd = 1;
    tick(); upd = 0;
    checks++;
    if (ack0 !== 1'b1) begin
      failures++; $display("FAIL coincident_ack: ack=%b need 1", ack0);
    end
    for (int i = 0; i < F; i++) begin
      tick(); checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL coincident cyc %0d: got %h need %h", i, obs_vec(), exp_vec());
      end
    end
    guard = 0;
    while (!(m_run && m_pos == 2 * (R + 1) + 2) && guard < 2 * F) begin
      tick(); guard++;
    end
    en = 0;
    tick(); checks++;
    if ({sel0, blank0} !== {4'h0, 1'b1}) begin
      failures++; $display("FAIL disable_dark: sel=%b blank=%b need 0000/1", sel0, blank0);
    end
    tick(); en = 1;
    for (int i = 0; i < F + 3; i++) begin
      tick(); checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL reenable cyc %0d: got %h need %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      upd = ($urandom_range(0, 7) == 0);
      sa  = 7'($urandom_range(0, 127));
      sb  = 7'($urandom_range(0, 127));
      en  = ($urandom_range(0, 39) != 0);
      tick(); checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL random cyc %0d: got %h need %h", i, obs_vec(), exp_vec());
      end
    end
    upd = 0; en = 1;
  endtask

  task automatic test_async_reset();
    int guard = 0;
    en = 1;
    while (!(m_run && m_pos == R + 3) && guard < 3 * F) begin
      tick(); guard++;
    end
    sa = 77; sb = 33; upd = 1;
    tick(); upd = 0;
    tick();
    #2 rst_n = 0;
    #1;
    checks++;
    if ({sel0, blank0, ack0, digit0, bin0} !== {4'h0, 1'b1, 1'b0, 4'h0, 7'h0}) begin
      failures++; $display("FAIL async_reset_dark: sel=%b blank=%b ack=%b digit=%0d bin=%0d", sel0, blank0, ack0, digit0, bin0);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < F + 2; i++) begin
      tick(); checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL after_async_reset cyc %0d: got %h need %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst_n = 0; en = 0; upd = 0; sa = 0; sb = 0;
    model_reset();
    test_reset();
    test_basic_scan();
    test_clamp_zero();
    test_tear_free();
    test_coincident_disable();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
